// File: rtl/adder.sv
// Unsigned adder with a combinational sum/carry path, a one-cycle registered result and a sticky overflow flag.
// Optional build macro ADDER_SATURATE_EN clamps the sum to all ones when the add carries out.
module adder #(
    parameter int OP_W  = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  new_operand,
    input  logic [ACC_W-1:0] current_value,
    input  logic             in_valid,
    input  logic             clear_sticky,
    output logic [ACC_W-1:0] output_value,
    output logic             carry_out,
    output logic [ACC_W-1:0] sum_q,
    output logic             out_valid,
    output logic             overflow_sticky
);

    // Selects between wrap-around and clamp-to-max depending on the build.
    function automatic logic [ACC_W-1:0] limit_sum(input logic [ACC_W:0] full);
`ifdef ADDER_SATURATE_EN
        if (full[ACC_W]) begin
            return {ACC_W{1'b1}};
        end
        return full[ACC_W-1:0];
`else
        return full[ACC_W-1:0];
`endif
    endfunction

    logic [ACC_W:0]   sum_full_p0;
    logic [ACC_W-1:0] sum_p1;
    logic             vld_p1;
    logic             sticky_p1;

    // Stage p0: combinational add, operand zero-extended so carries ripple through the upper bits
    always_comb begin
        sum_full_p0  = {1'b0, current_value} + {{(ACC_W + 1 - OP_W){1'b0}}, new_operand};
        output_value = limit_sum(sum_full_p0);
        carry_out    = sum_full_p0[ACC_W];
    end

    // Stage p1: registered result, valid flag and overflow history
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_p1    <= '0;
            vld_p1    <= 1'b0;
            sticky_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1 <= output_value;
            end
            if (in_valid && carry_out) begin
                sticky_p1 <= 1'b1;
            end else if (clear_sticky) begin
                sticky_p1 <= 1'b0;
            end
        end
    end

    assign sum_q           = sum_p1;
    assign out_valid       = vld_p1;
    assign overflow_sticky = sticky_p1;

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: directed corner cases followed by randomized traffic against an arithmetic model.
module tb_adder;
    localparam int OP_W  = 8;
    localparam int ACC_W = 16;

    logic             clk;
    logic             reset;
    logic [OP_W-1:0]  new_operand;
    logic [ACC_W-1:0] current_value;
    logic             in_valid;
    logic             clear_sticky;
    logic [ACC_W-1:0] output_value;
    logic             carry_out;
    logic [ACC_W-1:0] sum_q;
    logic             out_valid;
    logic             overflow_sticky;

    adder #(.OP_W(OP_W), .ACC_W(ACC_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .new_operand    (new_operand),
        .current_value  (current_value),
        .in_valid       (in_valid),
        .clear_sticky   (clear_sticky),
        .output_value   (output_value),
        .carry_out      (carry_out),
        .sum_q          (sum_q),
        .out_valid      (out_valid),
        .overflow_sticky(overflow_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic [ACC_W-1:0] sum;
        logic             sticky;
    } status_t;

    int tests = 0;
    int fails = 0;
    logic [ACC_W-1:0] result_q[$];
    status_t          status_q[$];

    // Reference state after the most recent modelled edge
    logic [ACC_W-1:0] m_sum;
    logic             m_vld;
    logic             m_sticky;
    bit               done;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected arithmetic: plain integer sum, then wrap or clamp
    function automatic longint ref_full(input longint op, input longint cv);
        return op + cv;
    endfunction

    function automatic longint ref_value(input longint full);
        longint modulus;
        modulus = longint'(1) << ACC_W;
`ifdef ADDER_SATURATE_EN
        if (full >= modulus) return modulus - 1;
`endif
        return full % modulus;
    endfunction

    task automatic drive(input logic [OP_W-1:0] op, input logic [ACC_W-1:0] cv,
                         input logic v, input logic clr, input logic rst, input bit stop);
        longint  full;
        logic    cy;
        status_t s;
        @(negedge clk);
        new_operand   = op;
        current_value = cv;
        in_valid      = v;
        clear_sticky  = clr;
        reset         = rst;
        #1;
        full = ref_full(longint'(op), longint'(cv));
        cy   = (full >> ACC_W) != 0;
        check("output_value", longint'(output_value), ref_value(full));
        check("carry_out", longint'(carry_out), longint'(cy));
        if (stop && (output_value != ACC_W'(ref_value(full)) || carry_out != cy)) begin
            $display("FAIL upper_bit_propagation: got 0x%0h/%0b expected 0x%0h/%0b",
                     output_value, carry_out, ref_value(full), cy);
            $fatal(1, "stopping on propagation error");
        end
        if (rst) begin
            m_sum = '0; m_vld = 1'b0; m_sticky = 1'b0;
        end else begin
            m_vld = v;
            if (v) begin
                m_sum = ACC_W'(ref_value(full));
                result_q.push_back(m_sum);
            end
            if (v && cy) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
        end
        s.vld = m_vld; s.sum = m_sum; s.sticky = m_sticky;
        status_q.push_back(s);
    endtask

    // Monitor: samples just after each rising edge
    initial begin
        status_t s;
        logic [ACC_W-1:0] r;
        while (!done) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (result_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    r = result_q.pop_front();
                    check("sum_q_result", longint'(sum_q), longint'(r));
                end
            end
            if (status_q.size() > 0) begin
                s = status_q.pop_front();
                check("out_valid", longint'(out_valid), longint'(s.vld));
                check("sum_q_state", longint'(sum_q), longint'(s.sum));
                check("overflow_sticky", longint'(overflow_sticky), longint'(s.sticky));
            end
        end
    end

    initial begin
        logic [OP_W-1:0]  rop;
        logic [ACC_W-1:0] rcv;
        done = 1'b0;
        m_sum = '0; m_vld = 1'b0; m_sticky = 1'b0;
        new_operand = '0; current_value = '0; in_valid = 1'b0;
        clear_sticky = 1'b0; reset = 1'b1;

        drive(8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        drive(8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        drive(8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        drive(8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        drive(8'h42, 16'h4200, 1'b1, 1'b0, 1'b0, 0);
        drive(8'h42, 16'h4220, 1'b0, 1'b0, 1'b0, 0);
        drive(8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b0, 1);
        drive(8'h01, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
        drive(8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
        drive(8'h42, 16'h4220, 1'b1, 1'b0, 1'b0, 0);
        drive(8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        drive(8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        // Set and clear on the same edge: set must win
        drive(8'h80, 16'hFF90, 1'b1, 1'b1, 1'b0, 0);
        drive(8'h42, 16'h4220, 1'b1, 1'b0, 1'b1, 0);
        drive(8'h01, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
        // Reset beats a carrying add
        drive(8'hFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 0);

        for (int i = 0; i < 400; i++) begin
            rop = OP_W'($urandom);
            rcv = ($urandom_range(0, 3) == 0) ? ACC_W'(16'hFF00 | $urandom_range(0, 255))
                                               : ACC_W'($urandom);
            drive(rop, rcv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 40) == 0), 0);
        end
        drive(8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("result_queue_drained", result_q.size(), 0);
        check("status_queue_drained", status_q.size(), 0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
